// File: rtl/overlap_add_buffer.sv
// overlap_add_buffer: sums overlapping time-domain frames into a circular
// accumulator and streams out the samples no later frame can still touch,
// saturated to the output width. A flush drains the pending tail after the
// final frame of a stream.
module overlap_add_buffer #(
  parameter int WIDTH      = 32,
  parameter int WIN_LENGTH = 480,
  parameter int HOP_LENGTH = 160,
  parameter int ACC_WIDTH  = WIDTH + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  input  logic signed [WIDTH-1:0] s_data,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic                    flush,
  output logic                    m_valid,
  output logic signed [WIDTH-1:0] m_data,
  output logic                    m_last,
  input  logic                    m_ready,
  output logic                    frame_err
);

  localparam int DEPTH       = 2 ** $clog2(WIN_LENGTH);
  localparam int ADDR_WIDTH  = $clog2(DEPTH);
  localparam int TAIL_LENGTH = WIN_LENGTH - HOP_LENGTH;
  localparam int CNT_WIDTH   = $clog2(WIN_LENGTH + 1);

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  IN_LAST   = CNT_WIDTH'(WIN_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0]  HOP_LAST  = CNT_WIDTH'(HOP_LENGTH - 1);
  localparam logic [CNT_WIDTH-1:0]  TAIL_LAST = CNT_WIDTH'(TAIL_LENGTH - 1);
  localparam logic [ADDR_WIDTH-1:0] HOP_STEP  = ADDR_WIDTH'(HOP_LENGTH);

  // Output clamp limits expressed at accumulator width
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    ACC_WIDTH'($signed({1'b1, {(WIDTH-1){1'b0}}}));

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN_HOP,
    DRAIN_TAIL
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_ptr_q, base_ptr_d;
  logic [CNT_WIDTH-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic                   frame_err_q, frame_err_d;

  logic signed [ACC_WIDTH-1:0] mem_q [DEPTH];

  logic                        mem_we;
  logic [ADDR_WIDTH-1:0]       mem_waddr;
  logic signed [ACC_WIDTH-1:0] mem_wdata;

  logic [ADDR_WIDTH-1:0]       in_addr;
  logic [ADDR_WIDTH-1:0]       out_addr;
  logic signed [ACC_WIDTH-1:0] in_acc;
  logic signed [ACC_WIDTH-1:0] out_acc;
  logic signed [WIDTH-1:0]     sat_val;
  logic [CNT_WIDTH-1:0]        burst_last;

  // Counters never exceed WIN_LENGTH-1 < DEPTH, so the low bits address the ring
  assign in_addr  = base_ptr_q + in_cnt_q[ADDR_WIDTH-1:0];
  assign out_addr = base_ptr_q + out_cnt_q[ADDR_WIDTH-1:0];
  assign in_acc   = mem_q[in_addr];
  assign out_acc  = mem_q[out_addr];

  assign frame_err = frame_err_q;

  // Clamp the accumulator word being drained into the signed output range
  always_comb begin
    sat_val = WIDTH'(out_acc);
    if (out_acc > SAT_MAX) begin
      sat_val = WIDTH'(SAT_MAX);
    end else if (out_acc < SAT_MIN) begin
      sat_val = WIDTH'(SAT_MIN);
    end
  end

  // Next-state, handshake outputs and the single accumulator write port
  always_comb begin
    state_d     = state_q;
    base_ptr_d  = base_ptr_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    frame_err_d = frame_err_q;
    mem_we      = 1'b0;
    mem_waddr   = in_addr;
    mem_wdata   = in_acc + ACC_WIDTH'(s_data);
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_last      = 1'b0;
    burst_last  = (state_q == DRAIN_TAIL) ? TAIL_LAST : HOP_LAST;

    case (state_q)
      ACCUM: begin
        s_ready = !flush;
        if (flush) begin
          if ((TAIL_LENGTH > 0) && (in_cnt_q == '0)) begin
            out_cnt_d = '0;
            state_d   = DRAIN_TAIL;
          end
        end else if (s_valid) begin
          mem_we = 1'b1;
          if ((in_cnt_q == IN_LAST) != s_last) begin
            frame_err_d = 1'b1;
          end
          if (in_cnt_q == IN_LAST) begin
            in_cnt_d  = '0;
            out_cnt_d = '0;
            state_d   = DRAIN_HOP;
          end else begin
            in_cnt_d = in_cnt_q + CNT_ONE;
          end
        end
      end

      DRAIN_HOP, DRAIN_TAIL: begin
        m_valid = 1'b1;
        m_data  = sat_val;
        m_last  = (out_cnt_q == burst_last);
        if (m_ready) begin
          mem_we    = 1'b1;
          mem_waddr = out_addr;
          mem_wdata = '0;
          out_cnt_d = out_cnt_q + CNT_ONE;
          if (out_cnt_q == burst_last) begin
            out_cnt_d  = '0;
            state_d    = ACCUM;
            base_ptr_d = (state_q == DRAIN_HOP) ? (base_ptr_q + HOP_STEP) : '0;
          end
        end
      end

      default: begin
        state_d = ACCUM;
      end
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      base_ptr_q  <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_ptr_q  <= base_ptr_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Accumulator ring; reset discards every partial sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_overlap_add_buffer.sv
// tb_overlap_add_buffer: drives frames into overlap_add_buffer and checks the
// output stream every cycle against a queue-based overlap-add model.
module tb_overlap_add_buffer;

  localparam int WIDTH = 16;
  localparam int WIN   = 8;
  localparam int HOP   = 4;
  localparam int TAIL  = WIN - HOP;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    s_valid = 1'b0;
  logic signed [WIDTH-1:0] s_data = '0;
  logic                    s_last = 1'b0;
  logic                    s_ready;
  logic                    flush = 1'b0;
  logic                    m_valid;
  logic signed [WIDTH-1:0] m_data;
  logic                    m_last;
  logic                    m_ready = 1'b1;
  logic                    frame_err;

  overlap_add_buffer #(
    .WIDTH(WIDTH),
    .WIN_LENGTH(WIN),
    .HOP_LENGTH(HOP),
    .ACC_WIDTH(WIDTH + 2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_last(s_last),
    .s_ready(s_ready),
    .flush(flush),
    .m_valid(m_valid),
    .m_data(m_data),
    .m_last(m_last),
    .m_ready(m_ready),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  longint pend[$];
  int     exp_data[$];
  bit     exp_last[$];
  int     got_data[$];
  bit     got_last[$];
  bit     model_err = 1'b0;
  int     ready_mode = 0;
  bit     ready_pat[$];
  int     frame_buf[WIN];
  bit     want_valid;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic timeout_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s: actual=timeout required=progress at %0t", name, $time);
    finish_run();
  endtask

  function automatic int sat(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Model: a completed frame is added at the next hop position of the output
  // signal, and the oldest HOP positions become final
  task automatic model_frame_done();
    while (pend.size() < WIN) pend.push_back(0);
    for (int i = 0; i < WIN; i++) pend[i] += frame_buf[i];
    for (int i = 0; i < HOP; i++) begin
      exp_data.push_back(sat(pend.pop_front()));
      exp_last.push_back(i == HOP - 1);
    end
  endtask

  // Model: a flush releases whatever tail the last frame left pending
  task automatic model_flush();
    longint v;
    for (int i = 0; i < TAIL; i++) begin
      v = (pend.size() != 0) ? pend.pop_front() : 0;
      exp_data.push_back(sat(v));
      exp_last.push_back(i == TAIL - 1);
    end
    pend.delete();
  endtask

  // m_ready driver: always ready, random, or a scripted pattern
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = (ready_pat.size() != 0) ? ready_pat.pop_front() : 1'b1;
    endcase
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      want_valid = (exp_data.size() != 0);
      checkOutput("m_valid", m_valid, want_valid);
      checkOutput("s_ready", s_ready, !want_valid && !flush);
      checkOutput("frame_err", frame_err, model_err);
      if (want_valid && m_valid) begin
        checkOutput("m_data", m_data, exp_data[0]);
        checkOutput("m_last", m_last, exp_last[0]);
        if (m_ready) begin
          got_data.push_back(int'(m_data));
          got_last.push_back(m_last);
          void'(exp_data.pop_front());
          void'(exp_last.pop_front());
        end
      end else if (!m_valid) begin
        checkOutput("m_data_idle", m_data, 0);
        checkOutput("m_last_idle", m_last, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send frame_buf as one frame, s_last at last_pos; optionally sprinkle
  // mid-frame flush pulses, which must be ignored
  task automatic applyStimulus(input int last_pos, input bit inject);
    int  waited;
    bit  accepted;
    for (int i = 0; i < WIN; i++) begin
      s_valid  = 1'b1;
      s_data   = WIDTH'(frame_buf[i]);
      s_last   = (i == last_pos);
      waited   = 0;
      accepted = 1'b0;
      while (!accepted) begin
        flush = inject && (i > 0) && ($urandom_range(0, 5) == 0);
        @(negedge clk);
        accepted = s_ready;
        @(posedge clk);
        #1;
        if (!accepted) begin
          waited++;
          if (waited > 100) timeout_fail("s_ready_wait");
        end
      end
      flush = 1'b0;
      if ((i == WIN - 1) != (i == last_pos)) model_err = 1'b1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    model_frame_done();
  endtask

  task automatic doFlush();
    bit take;
    flush = 1'b1;
    @(negedge clk);
    take = (exp_data.size() == 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (take) model_flush();
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (exp_data.size() != 0) begin
      tick();
      waited++;
      if (waited > 400) timeout_fail("drain_wait");
    end
  endtask

  task automatic set_frame(input int v);
    for (int i = 0; i < WIN; i++) frame_buf[i] = v;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_last.delete();
  endtask

  task automatic check_burst(input string name, input int idx, input int data, input bit last);
    if (idx < got_data.size()) begin
      checkOutput(name, got_data[idx], data);
      checkOutput({name, "_last"}, got_last[idx], last);
    end else begin
      checkOutput({name, "_missing"}, got_data.size(), idx + 1);
    end
  endtask

  initial begin
    #3;
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_m_data", m_data, 0);
    checkOutput("rst_m_last", m_last, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    tick();
    rst_n = 1'b1;

    $display("[TB] three frames of +1");
    clear_got();
    set_frame(1);
    repeat (3) applyStimulus(WIN - 1, 1'b0);
    wait_idle();
    checkOutput("t1_count", got_data.size(), 12);
    for (int k = 0; k < 12; k++) check_burst("t1_burst", k, (k < 4) ? 1 : 2, (k % 4) == 3);

    $display("[TB] flush tail then fresh frame");
    clear_got();
    doFlush();
    wait_idle();
    for (int k = 0; k < 4; k++) check_burst("t2_tail", k, 1, k == 3);
    clear_got();
    set_frame(5);
    applyStimulus(WIN - 1, 1'b0);
    wait_idle();
    for (int k = 0; k < 4; k++) check_burst("t2_fresh", k, 5, k == 3);
    doFlush();
    wait_idle();

    $display("[TB] saturation");
    clear_got();
    set_frame(30000);
    repeat (2) applyStimulus(WIN - 1, 1'b0);
    wait_idle();
    for (int k = 0; k < 8; k++) check_burst("t3_pos", k, (k < 4) ? 30000 : 32767, (k % 4) == 3);
    doFlush();
    wait_idle();
    clear_got();
    set_frame(-30000);
    repeat (2) applyStimulus(WIN - 1, 1'b0);
    wait_idle();
    for (int k = 4; k < 8; k++) check_burst("t3_neg", k, -32768, k == 7);
    doFlush();
    wait_idle();

    $display("[TB] stalled drain");
    clear_got();
    for (int i = 0; i < WIN; i++) frame_buf[i] = i + 1;
    ready_mode = 2;
    applyStimulus(WIN - 1, 1'b0);
    ready_pat.push_back(1'b1);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b1);
    wait_idle();
    checkOutput("t4_count", got_data.size(), 4);
    for (int k = 0; k < 4; k++) check_burst("t4_burst", k, k + 1, k == 3);
    ready_mode = 0;
    doFlush();
    wait_idle();

    $display("[TB] framing error");
    for (int i = 0; i < WIN; i++) frame_buf[i] = int'($urandom_range(0, 200)) - 100;
    applyStimulus(5, 1'b0);
    checkOutput("t5_err_set", frame_err, 1);
    wait_idle();
    applyStimulus(WIN - 1, 1'b0);
    wait_idle();
    checkOutput("t5_err_sticky", frame_err, 1);
    doFlush();
    wait_idle();

    $display("[TB] random frames");
    ready_mode = 1;
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < WIN; i++) begin
        if (f % 3 == 0) frame_buf[i] = int'($urandom_range(0, 65535)) - 32768;
        else frame_buf[i] = int'($urandom_range(0, 2000)) - 1000;
      end
      applyStimulus(WIN - 1, 1'b1);
      if ($urandom_range(0, 2) == 0) doFlush();
      if (f == 4) begin
        wait_idle();
        doFlush();
      end
    end
    wait_idle();
    doFlush();
    wait_idle();
    ready_mode = 0;

    $display("[TB] reset during drain");
    set_frame(9);
    ready_mode = 2;
    applyStimulus(WIN - 1, 1'b0);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0);
    ready_pat.push_back(1'b0);
    tick();
    rst_n = 1'b0;
    exp_data.delete();
    exp_last.delete();
    pend.delete();
    ready_pat.delete();
    model_err = 1'b0;
    #1;
    checkOutput("t7_m_valid", m_valid, 0);
    checkOutput("t7_s_ready", s_ready, 1);
    checkOutput("t7_m_data", m_data, 0);
    checkOutput("t7_frame_err", frame_err, 0);
    ready_mode = 0;
    tick();
    rst_n = 1'b1;
    clear_got();
    set_frame(7);
    applyStimulus(WIN - 1, 1'b0);
    wait_idle();
    for (int k = 0; k < 4; k++) check_burst("t7_clean", k, 7, k == 3);
    doFlush();
    wait_idle();
    for (int k = 4; k < 8; k++) check_burst("t7_tail", k, 7, k == 7);

    finish_run();
  end

endmodule

// File: doc/overlap_add_buffer.md
# overlap_add_buffer

Inverse-direction companion to the framing circular buffer in the MEL/STFT pipeline. It accepts reconstructed time-domain frames of WIN_LENGTH signed samples and sums each frame into a circular accumulator at offsets of HOP_LENGTH. After each frame it emits the HOP_LENGTH samples that no later frame can touch, saturated to WIDTH bits. It sits after the inverse transform and windowing stage, and drives the audio output stream.

## Interface
- WIDTH, 32, signed sample width of s_data and m_data
- WIN_LENGTH, 480, samples per input frame
- HOP_LENGTH, 160, frame advance; requires HOP_LENGTH <= WIN_LENGTH
- ACC_WIDTH, WIDTH+2, signed accumulator width; must be >= WIDTH + $clog2(ceil(WIN_LENGTH/HOP_LENGTH))
- Derived: DEPTH = 2**$clog2(WIN_LENGTH), ADDR_WIDTH = $clog2(DEPTH)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- s_valid  in  1  input sample valid
- s_data  in  WIDTH  signed input sample
- s_last  in  1  marks the final sample of the frame
- s_ready  out  1  input accept
- flush  in  1  one-cycle request to drain the pending tail
- m_valid  out  1  output sample valid
- m_data  out  WIDTH  saturated signed output sample
- m_last  out  1  last sample of the current drain burst
- m_ready  in  1  output accept
- frame_err  out  1  sticky s_last framing error

## Operation
- Storage: mem[0:DEPTH-1] of ACC_WIDTH signed, all zero after reset. base_ptr (ADDR_WIDTH), in_cnt, out_cnt.
- States: ACCUM, DRAIN_HOP, DRAIN_TAIL.
- ACCUM: s_ready = !flush. On s_valid&s_ready: mem[(base_ptr+in_cnt) mod DEPTH] <= that location + sign-extended s_data; in_cnt++.
  - When in_cnt==WIN_LENGTH-1 is accepted: in_cnt<=0, out_cnt<=0, go to DRAIN_HOP.
- Framing check: s_last accepted with in_cnt!=WIN_LENGTH-1, or s_last low at in_cnt==WIN_LENGTH-1, sets frame_err. frame_err clears only on reset. The frame boundary is always set by in_cnt; s_last never realigns it.
- DRAIN_HOP: m_valid=1. m_data = sat(mem[(base_ptr+out_cnt) mod DEPTH]).
  - On m_valid&m_ready: that location <= 0; out_cnt++.
  - At out_cnt==HOP_LENGTH-1 handshake: base_ptr <= (base_ptr+HOP_LENGTH) mod DEPTH; return to ACCUM.
- flush: honoured only in ACCUM with in_cnt==0. Otherwise ignored, with no effect and no stored request.
  - When honoured: no sample is accepted that cycle; out_cnt<=0; go to DRAIN_TAIL.
- DRAIN_TAIL: same as DRAIN_HOP, but runs for WIN_LENGTH-HOP_LENGTH samples.
  - At the final handshake, base_ptr<=0 and state returns to ACCUM.
  - If WIN_LENGTH==HOP_LENGTH, flush is a no-op.
- sat(): above 2^(WIDTH-1)-1 outputs 2^(WIDTH-1)-1; below -2^(WIDTH-1) outputs -2^(WIDTH-1); otherwise truncate to WIDTH bits.
- Accumulator arithmetic is ACC_WIDTH two's complement. Overflow cannot occur within the parameter constraint.
- m_last = m_valid & (out_cnt == burst_length-1).

## Timing
- Reset values: state ACCUM, base_ptr 0, in_cnt 0, out_cnt 0, mem all 0, m_valid 0, m_data 0, m_last 0, frame_err 0, s_ready 1.
- One input per cycle, with no bubbles within a frame.
- Read-modify-write completes in the accept cycle. Back-to-back accepts always target distinct addresses, because WIN_LENGTH <= DEPTH.
- First output: m_valid rises the cycle after the last frame sample is accepted. Minimum latency is 1 cycle.
- Drain throughput is one sample per cycle while m_ready=1.
- m_data and m_last hold stable while m_valid & !m_ready.
- m_data = 0 whenever m_valid = 0.
- s_ready is low throughout both drain states, and returns high the cycle after the final drain handshake.
- Sustained rate: WIN_LENGTH+HOP_LENGTH cycles per frame.
- Address wrap is modulo DEPTH on every access. base_ptr+HOP_LENGTH wraps the same way.
- rst_n asserted mid-frame or mid-drain: immediate return to reset values. All partial sums are discarded.

## Test plan
- WIN=8, HOP=4, WIDTH=16; feed 3 frames of all +1 samples -> bursts of 4 samples: [1,1,1,1], [2,2,2,2], [2,2,2,2]. m_last is set on the 4th sample of each burst.
- Continue the previous case with a flush at in_cnt==0 -> tail burst [1,1,1,1] with m_last on the 4th. Then base_ptr==0, and a fresh frame of +5 drains [5,5,5,5].
- WIDTH=16: two overlapping frames of +30000 -> overlap samples output 32767. Repeat with -30000 -> overlap samples output -32768.
- m_ready toggled 1-0-0-1 during a drain -> no sample lost or duplicated. m_data is stable while stalled. s_ready stays 0 until the final handshake.
- s_last asserted at in_cnt==5 with WIN=8 -> frame_err=1 from the next cycle. The frame still ends after 8 samples, and frame_err persists until reset.
- Defaults (480/160): 10 frames of a ramp, checked against a reference overlap-add model, including base_ptr wrap past 511. Reset asserted mid-DRAIN_HOP -> m_valid=0, s_ready=1, and the next output equals the first hop of a clean frame.
